// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops, each acting as a JK, D, T or SR flop depending on a shared run-time mode.
// Latency: q, err_bits, sr_err and chg_cnt update one clock after the sampling edge; qb follows q combinationally.
// Backpressure: none; en=0 freezes q, sr_err and chg_cnt, and clr overrides en.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (loads RST_VAL, clears flags and counter)
//   en       clock enable; when low, q, sr_err and chg_cnt hold
//   clr      synchronous clear, higher priority than en
//   mode     00=JK, 01=D, 10=T, 11=SR, shared by all bits
//   j        per-bit J / D / T / S input
//   k        per-bit K / R input (unused in D and T modes)
//   q, qb    bank state and its complement
//   err_bits bits that saw S=R=1 on the most recent edge
//   sr_err   sticky flag, set by any illegal SR bit, cleared only by clr or rst
//   chg_cnt  saturating count of enabled edges on which q changed

module jk_ff_bank #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] err_bits,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] next_err;

    // Per-bit next state for an enabled edge. Each bit is decoded on its own
    // from {j[i], k[i]}; the mode only selects which truth table applies.
    always_comb begin
        next_q   = q;
        next_err = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_JK: begin
                    case ({j[i], k[i]})
                        2'b01:   next_q[i] = 1'b0;
                        2'b10:   next_q[i] = 1'b1;
                        2'b11:   next_q[i] = ~q[i];
                        default: next_q[i] = q[i];
                    endcase
                end
                MODE_D: begin
                    next_q[i] = j[i];
                end
                MODE_T: begin
                    next_q[i] = q[i] ^ j[i];
                end
                MODE_SR: begin
                    case ({j[i], k[i]})
                        2'b01:   next_q[i] = 1'b0;
                        2'b10:   next_q[i] = 1'b1;
                        // S=R=1 is undefined for a real SR latch: keep the
                        // old value and report the bit instead of guessing.
                        2'b11: begin
                            next_q[i]   = q[i];
                            next_err[i] = 1'b1;
                        end
                        default: next_q[i] = q[i];
                    endcase
                end
                default: next_q[i] = q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RST_VAL;
            err_bits <= '0;
            sr_err   <= 1'b0;
            chg_cnt  <= '0;
        end else if (clr) begin
            q        <= RST_VAL;
            err_bits <= '0;
            sr_err   <= 1'b0;
            chg_cnt  <= '0;
        end else if (en) begin
            q        <= next_q;
            err_bits <= next_err;
            if (next_err != '0) begin
                sr_err <= 1'b1;
            end
            // One count per edge, however many bits flipped; stick at max.
            if ((next_q != q) && (chg_cnt != CNT_MAX)) begin
                chg_cnt <= chg_cnt + CNT_ONE;
            end
        end else begin
            // err_bits describes only the latest edge, so an idle edge clears it.
            err_bits <= '0;
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_jk_ff_bank.sv
module tb_jk_ff_bank;

    localparam int W = 4;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] j = '0;
    logic [W-1:0] k = '0;
    logic [W-1:0] q, qb, err_bits;
    logic         sr_err;
    logic [C-1:0] chg_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    jk_ff_bank #(.WIDTH(W), .RST_VAL(4'b0000), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .j(j), .k(k), .q(q), .qb(qb), .err_bits(err_bits),
        .sr_err(sr_err), .chg_cnt(chg_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: whole-word boolean equations for each flop type.
    int m_q, m_err, m_sr, m_cnt;

    function automatic int model_next(input int cq, input int md, input int jj, input int kk);
        int r;
        case (md)
            0: r = (jj & ~cq) | (~kk & cq);                        // characteristic eq. of JK
            1: r = jj;
            2: r = cq ^ jj;
            default: r = (cq & ~(kk & ~jj)) | (jj & ~kk);          // set wins only when R=0
        endcase
        return r & 15;
    endfunction

    always @(posedge clk or posedge rst) begin
        int nq;
        if (rst) begin
            m_q = 0; m_err = 0; m_sr = 0; m_cnt = 0;
        end else if (clr) begin
            m_q = 0; m_err = 0; m_sr = 0; m_cnt = 0;
        end else if (en) begin
            nq    = model_next(m_q, int'(mode), int'(j), int'(k));
            m_err = (mode == 2'b11) ? int'(j & k) : 0;
            if (m_err != 0) m_sr = 1;
            if (nq != m_q && m_cnt < 15) m_cnt = m_cnt + 1;
            m_q = nq;
        end else begin
            m_err = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("q",        int'(q),        m_q);
            chk("qb",       int'(qb),       (~m_q) & 15);
            chk("err_bits", int'(err_bits), m_err);
            chk("sr_err",   int'(sr_err),   m_sr);
            chk("chg_cnt",  int'(chg_cnt),  m_cnt);
        end
    end

    // Apply inputs 2 time units after a rising edge, then wait through the next edge.
    task automatic tick(input logic e, input logic c, input logic [1:0] m,
                        input logic [W-1:0] jj, input logic [W-1:0] kk);
        en = e; clr = c; mode = m; j = jj; k = kk;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        chk("rst_q_async",   int'(q),       0);
        chk("rst_qb_async",  int'(qb),      15);
        chk("rst_cnt_async", int'(chg_cnt), 0);
        chk("rst_sr_async",  int'(sr_err),  0);
        chk("rst_err_async", int'(err_bits), 0);
        rst = 1'b0;
    endtask

    initial begin
        // Hold reset over a couple of edges; state must stay at reset value.
        repeat (2) @(posedge clk);
        #2;
        chk("reset_q",   int'(q),       0);
        chk("reset_qb",  int'(qb),      15);
        chk("reset_cnt", int'(chg_cnt), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // 1: load 1010 then async reset between edges
        tick(1, 0, 2'b01, 4'b1010, 4'b0000);
        chk("load_1010", int'(q), 10);
        pulse_rst();

        // 2: JK truth table, two identical edges
        tick(1, 0, 2'b00, 4'b0011, 4'b0101);
        chk("jk_edge1", int'(q), 4'b0011);
        tick(1, 0, 2'b00, 4'b0011, 4'b0101);
        chk("jk_edge2", int'(q), 4'b0010);
        chk("jk_cnt",   int'(chg_cnt), 2);

        // 3: D then T then T-hold
        tick(1, 0, 2'b01, 4'b1001, 4'b0000);
        chk("d_mode", int'(q), 4'b1001);
        tick(1, 0, 2'b10, 4'b1111, 4'b0000);
        chk("t_mode", int'(q), 4'b0110);
        tick(1, 0, 2'b10, 4'b0000, 4'b0000);
        chk("t_hold", int'(q), 4'b0110);
        chk("dt_cnt", int'(chg_cnt), 4);

        // 4: SR illegal from q=0101
        tick(1, 0, 2'b01, 4'b0101, 4'b0000);
        tick(1, 0, 2'b11, 4'b1100, 4'b1010);
        chk("sr_q",      int'(q),        4'b0101);
        chk("sr_errb",   int'(err_bits), 4'b1000);
        chk("sr_flag",   int'(sr_err),   1);
        tick(1, 0, 2'b11, 4'b0000, 4'b0000);
        chk("sr_errb_clr",  int'(err_bits), 0);
        chk("sr_flag_stky", int'(sr_err),   1);

        // 5: enable low holds; clear beats enable
        repeat (3) tick(0, 0, 2'b10, 4'b1111, 4'b0000);
        chk("en_hold_q",   int'(q),       4'b0101);
        chk("en_hold_cnt", int'(chg_cnt), 5);
        tick(1, 1, 2'b10, 4'b1111, 4'b0000);
        chk("clr_q",   int'(q),       0);
        chk("clr_cnt", int'(chg_cnt), 0);
        chk("clr_sr",  int'(sr_err),  0);

        // 6: counter saturation
        repeat (16) tick(1, 0, 2'b10, 4'b0001, 4'b0000);
        chk("sat_16", int'(chg_cnt), 15);
        repeat (3) tick(1, 0, 2'b10, 4'b0001, 4'b0000);
        chk("q0_odd", int'(q), 4'b0001);
        tick(1, 0, 2'b10, 4'b0001, 4'b0000);
        chk("sat_20", int'(chg_cnt), 15);
        chk("q0_even", int'(q), 0);

        // Randomized traffic, occasional clear and mid-cycle reset
        for (int n = 0; n < 400; n++) begin
            logic e, c;
            e = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) pulse_rst();
            tick(e, c, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
